// File: rtl/imem_loader.sv
// imem_loader: packs a little-endian byte stream into instruction words
// and writes them to instruction memory while holding the core in reset.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module imem_loader #(
  parameter int SIZE = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  input  logic                    byte_last,
  output logic                    byte_ready,
  output logic                    imem_we,
  output logic [`WORD-1:0]        imem_addr,
  output logic [`INSTR_LEN-1:0]   imem_wdata,
  output logic                    cpu_hold,
  output logic                    load_done,
  output logic                    load_error,
  output logic [$clog2(SIZE):0]   word_count
);

  localparam int CW = $clog2(SIZE) + 1;

  typedef enum logic [2:0] {
    IDLE, COLLECT, WRITE, DONE, ERROR
  } state_t;

  state_t state;
  state_t nxt;

  logic [1:0]            idx;
  logic [`INSTR_LEN-1:0] shreg;
  logic                  last_q;
  logic [CW-1:0]         wcount;
  logic                  accept;
  logic                  full;
  logic                  begin_load;

  assign accept     = byte_valid && byte_ready;
  assign full       = (wcount == CW'(SIZE));
  assign begin_load = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: begin
        if (start) nxt = COLLECT;
      end
      COLLECT: begin
        if (accept) begin
          // overflow or truncated final word aborts before any write
          if (full || (byte_last && idx != 2'd3)) nxt = ERROR;
          else if (idx == 2'd3)                   nxt = WRITE;
        end
      end
      WRITE:   nxt = last_q ? DONE : COLLECT;
      ERROR:   nxt = ERROR;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    byte_ready = (state == COLLECT);
    imem_we    = (state == WRITE);
    cpu_hold   = (state != DONE);
    load_done  = (state == DONE);
    load_error = (state == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      shreg  <= '0;
      last_q <= 1'b0;
      wcount <= '0;
    end else if (begin_load) begin
      idx    <= '0;
      shreg  <= '0;
      last_q <= 1'b0;
      wcount <= '0;
    end else if (state == COLLECT && accept) begin
      shreg[8*idx +: 8] <= byte_data;
      idx               <= idx + 2'd1;
      last_q            <= byte_last;
    end else if (state == WRITE) begin
      if (!full) wcount <= wcount + CW'(1);
    end
  end

  // address tracks the word count, so it is cleared and advanced with it
  assign imem_addr  = `WORD'({wcount, 2'b00});
  assign imem_wdata = shreg;
  assign word_count = wcount;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the imem_loader byte packer.
// An array stands in for instruction memory as iFetch would read it.
`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module tb_imem_loader;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic                  byte_valid = 1'b0;
  logic [7:0]            byte_data = 8'h00;
  logic                  byte_last = 1'b0;
  logic                  byte_ready;
  logic                  imem_we;
  logic [`WORD-1:0]      imem_addr;
  logic [`INSTR_LEN-1:0] imem_wdata;
  logic                  cpu_hold;
  logic                  load_done;
  logic                  load_error;
  logic [4:0]            word_count;

  imem_loader #(.SIZE(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int wa[$];
  int wt[$];
  logic [31:0] wd[$];
  logic [31:0] mem [16];
  logic [31:0] prog [4];

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(int'(imem_addr[31:0]));
      wd.push_back(imem_wdata);
      wt.push_back(cyc);
      mem[imem_addr[5:2]] = imem_wdata;
      check("rdy_in_wr", {63'd0, byte_ready}, 64'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic last,
                           input int gap);
    int n;
    repeat (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    byte_last  = last;
    n = 0;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rdy_timeout", 64'(n), 64'd0);
    @(negedge clk);
    byte_valid = 1'b0;
    byte_last  = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic last,
                           input logic rnd);
    for (int k = 0; k < 4; k++)
      send_byte(w[8*k +: 8], last && (k == 3),
                rnd ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int b;
    prog[0] = 32'hF84402C9;
    prog[1] = 32'h8B09026A;
    prog[2] = 32'hCB0A028B;
    prog[3] = 32'hF80602CB;

    // reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", {63'd0, byte_ready}, 64'd0);
    check("rst_we",    {63'd0, imem_we},    64'd0);
    check("rst_addr",  imem_addr,           64'd0);
    check("rst_wdata", 64'(imem_wdata),     64'd0);
    check("rst_hold",  {63'd0, cpu_hold},   64'd1);
    check("rst_done",  {63'd0, load_done},  64'd0);
    check("rst_err",   {63'd0, load_error}, 64'd0);
    check("rst_wc",    64'(word_count),     64'd0);
    reset = 1'b0;
    @(negedge clk);

    // single word
    pulse_start();
    send_byte(8'hC9, 1'b0, 0);
    send_byte(8'h02, 1'b0, 0);
    send_byte(8'h44, 1'b0, 0);
    send_byte(8'hF8, 1'b1, 0);
    check("w1_we",    {63'd0, imem_we},   64'd1);
    check("w1_addr",  imem_addr,          64'd0);
    check("w1_wdata", 64'(imem_wdata),    64'hF84402C9);
    check("w1_hold_wr", {63'd0, cpu_hold}, 64'd1);
    @(negedge clk);
    check("w1_done",  {63'd0, load_done}, 64'd1);
    check("w1_hold",  {63'd0, cpu_hold},  64'd0);
    check("w1_wc",    64'(word_count),    64'd1);
    check("w1_nwr",   64'(wd.size()),     64'd1);

    // four words, byte_valid held high
    b = wd.size();
    pulse_start();
    check("st_hold", {63'd0, cpu_hold},  64'd1);
    check("st_done", {63'd0, load_done}, 64'd0);
    for (int i = 0; i < 4; i++) send_word(prog[i], i == 3, 1'b0);
    @(negedge clk);
    check("h4_nwr", 64'(wd.size() - b), 64'd4);
    for (int i = 0; i < 4 && b + i < wd.size(); i++) begin
      check($sformatf("h4_addr%0d", i), 64'(wa[b+i]), 64'(4*i));
      check($sformatf("h4_data%0d", i), 64'(wd[b+i]), 64'(prog[i]));
      if (i > 0)
        check($sformatf("h4_gap%0d", i), 64'(wt[b+i] - wt[b+i-1]), 64'd5);
    end
    check("h4_done", {63'd0, load_done}, 64'd1);
    check("h4_wc",   64'(word_count),    64'd4);
    check("h4_read4", 64'(mem[1]),       64'h8B09026A);

    // same stream, random stalls
    b = wd.size();
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(prog[i], i == 3, 1'b1);
    @(negedge clk);
    check("r4_nwr", 64'(wd.size() - b), 64'd4);
    for (int i = 0; i < 4 && b + i < wd.size(); i++) begin
      check($sformatf("r4_addr%0d", i), 64'(wa[b+i]), 64'(4*i));
      check($sformatf("r4_data%0d", i), 64'(wd[b+i]), 64'(prog[i]));
    end
    check("r4_done", {63'd0, load_done}, 64'd1);

    // truncated word 1
    do_reset();
    b = wd.size();
    pulse_start();
    send_word(prog[0], 1'b0, 1'b0);
    send_byte(8'h6A, 1'b0, 0);
    send_byte(8'h02, 1'b1, 0);
    check("tr_err",  {63'd0, load_error}, 64'd1);
    check("tr_hold", {63'd0, cpu_hold},   64'd1);
    @(negedge clk);
    check("tr_nwr",  64'(wd.size() - b), 64'd1);
    if (wd.size() > b) check("tr_data0", 64'(wd[b]), 64'hF84402C9);
    pulse_start();
    @(negedge clk);
    check("tr_stign", {63'd0, load_error}, 64'd1);
    check("tr_rdy",   {63'd0, byte_ready}, 64'd0);
    check("tr_done",  {63'd0, load_done},  64'd0);

    // overflow: 17 words into a 16-word memory
    do_reset();
    b = wd.size();
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(32'h1000 + i, 1'b0, 1'b0);
    send_byte(8'hAA, 1'b0, 0);
    @(negedge clk);
    check("ov_nwr",  64'(wd.size() - b), 64'd16);
    if (wd.size() >= b + 16)
      check("ov_last_addr", 64'(wa[b+15]), 64'h3C);
    check("ov_err", {63'd0, load_error}, 64'd1);
    check("ov_wc",  64'(word_count),     64'd16);

    // exactly 16 words is legal
    do_reset();
    b = wd.size();
    pulse_start();
    for (int i = 0; i < 16; i++) send_word(32'h2000 + i, i == 15, 1'b0);
    @(negedge clk);
    check("f16_nwr",  64'(wd.size() - b), 64'd16);
    check("f16_done", {63'd0, load_done},  64'd1);
    check("f16_err",  {63'd0, load_error}, 64'd0);
    check("f16_wc",   64'(word_count),     64'd16);
    check("f16_mem",  64'(mem[15]),        64'h200F);

    // reset during WRITE of word 2
    do_reset();
    b = wd.size();
    pulse_start();
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b0, 1'b0);
    check("rw_we", {63'd0, imem_we}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rw_we0",  {63'd0, imem_we},    64'd0);
    check("rw_wc",   64'(word_count),     64'd0);
    check("rw_hold", {63'd0, cpu_hold},   64'd1);
    check("rw_rdy",  {63'd0, byte_ready}, 64'd0);
    check("rw_nwr",  64'(wd.size() - b),  64'd3);
    b = wd.size();
    pulse_start();
    send_word(prog[3], 1'b1, 1'b0);
    @(negedge clk);
    check("rw_re_nwr", 64'(wd.size() - b), 64'd1);
    if (wd.size() > b) begin
      check("rw_re_addr", 64'(wa[b]), 64'd0);
      check("rw_re_data", 64'(wd[b]), 64'hF80602CB);
    end
    check("rw_re_done", {63'd0, load_done}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
